// File: rtl/uart_pkg.sv
// uart_pkg: shared UART receiver state type and oversample tick divisor helper
package uart_pkg;
  typedef enum logic [2:0] {IDLE, START, DATA, STOP, BRK} rx_state_t;
  function automatic int calc_tick_limit(input int clock_freq, input int baud_rate, input int oversample);
    return (clock_freq + baud_rate * oversample / 2) / (baud_rate * oversample) - 1;
  endfunction
endpackage

// File: rtl/uart_os_tick_gen.sv
// uart_os_tick_gen: free-running counter pulsing tick once per oversample period
module uart_os_tick_gen import uart_pkg::*; #(
  parameter int CLOCK_FREQ = 50000000,
  parameter int BAUD_RATE  = 9600,
  parameter int OVERSAMPLE = 16
) (
  input  logic clk,
  input  logic rst_n,
  output logic tick
);
  localparam int TICK_LIMIT = calc_tick_limit(CLOCK_FREQ, BAUD_RATE, OVERSAMPLE);
  localparam int CW = TICK_LIMIT > 0 ? $clog2(TICK_LIMIT + 1) : 1;
  logic [CW-1:0] cnt;
  assign tick = cnt == CW'(TICK_LIMIT);
  always_ff @(posedge clk) cnt <= (!rst_n || tick) ? '0 : cnt + 1'b1;
endmodule

// File: rtl/uart_rx_oversampled.sv
// uart_rx_oversampled: 16x oversampled UART receiver with valid/ready byte output
module uart_rx_oversampled import uart_pkg::*; #(
  parameter int CLOCK_FREQ = 50000000,
  parameter int BAUD_RATE  = 9600,
  parameter int OVERSAMPLE = 16,
  parameter int DATA_BITS  = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 rx_in,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  input  logic                 rx_ready,
  output logic                 frame_err,
  output logic                 overrun_err,
  output logic                 busy
);
  localparam int SW = $clog2(OVERSAMPLE);
  localparam int BW = $clog2(DATA_BITS + 1);
  rx_state_t state, nxt;
  logic rx_m, rxs, tick, half, full, stop_smp, s_clr;
  logic [SW-1:0] s_cnt;
  logic [BW-1:0] b_cnt;
  logic [DATA_BITS-1:0] shreg;
  uart_os_tick_gen #(.CLOCK_FREQ(CLOCK_FREQ), .BAUD_RATE(BAUD_RATE), .OVERSAMPLE(OVERSAMPLE)) u_tick (
    .clk(clk), .rst_n(rst_n), .tick(tick)
  );
  assign half = s_cnt == SW'(OVERSAMPLE / 2 - 1);
  assign full = s_cnt == SW'(OVERSAMPLE - 1);
  always_ff @(posedge clk) {rxs, rx_m} <= !rst_n ? 2'b11 : {rx_m, rx_in};
  always_ff @(posedge clk) state <= !rst_n ? IDLE : nxt;
  always_comb begin
    nxt = state;
    if (tick)
      case (state)
        IDLE:    nxt = rxs ? IDLE : START;
        START:   nxt = !half ? START : (rxs ? IDLE : DATA);
        DATA:    nxt = (full && b_cnt == BW'(DATA_BITS - 1)) ? STOP : DATA;
        STOP:    nxt = !full ? STOP : (rxs ? IDLE : BRK);
        BRK:     nxt = rxs ? IDLE : BRK;
        default: nxt = IDLE;
      endcase
  end
  always_comb begin
    busy     = state != IDLE;
    stop_smp = tick && state == STOP && full;
    s_clr    = state == IDLE || state == BRK || (state == START && half) || full;
  end
  always_ff @(posedge clk)
    if (!rst_n) begin
      s_cnt       <= '0;
      b_cnt       <= '0;
      shreg       <= '0;
      rx_data     <= '0;
      rx_valid    <= 1'b0;
      frame_err   <= 1'b0;
      overrun_err <= 1'b0;
    end else begin
      frame_err   <= stop_smp && !rxs;
      overrun_err <= stop_smp && rxs && rx_valid && !rx_ready;
      if (tick) begin
        s_cnt <= s_clr ? '0 : s_cnt + 1'b1;
        if (state == START) b_cnt <= '0;
        if (state == DATA && full) begin
          b_cnt <= b_cnt + 1'b1;
          shreg <= {rxs, shreg[DATA_BITS-1:1]};
        end
      end
      // a byte landing on an accepting edge replaces the consumed one without a gap
      if (stop_smp && rxs && (!rx_valid || rx_ready)) begin
        rx_data  <= shreg;
        rx_valid <= 1'b1;
      end else if (rx_ready) rx_valid <= 1'b0;
    end
endmodule

// File: tb/tb_uart_rx_oversampled.sv
// tb_uart_rx_oversampled: directed self-checking bench for uart_rx_oversampled
module tb_uart_rx_oversampled;
  localparam int BIT = 32;
  logic clk, rst_n, rx_in, rx_ready;
  logic [7:0] rx_data;
  logic rx_valid, frame_err, overrun_err, busy;
  int checks = 0, errors = 0;
  int cyc = 0, fe_cnt = 0, ov_cnt = 0, ov_cyc = 0;
  int fe0, ov0, t1, t2, off;
  logic [7:0] acc[$];

  uart_rx_oversampled #(.CLOCK_FREQ(3200000), .BAUD_RATE(100000), .OVERSAMPLE(16), .DATA_BITS(8)) dut (
    .clk(clk), .rst_n(rst_n), .rx_in(rx_in), .rx_data(rx_data), .rx_valid(rx_valid),
    .rx_ready(rx_ready), .frame_err(frame_err), .overrun_err(overrun_err), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (rst_n && rx_valid && rx_ready) acc.push_back(rx_data);
  end
  always @(negedge clk) begin
    if (frame_err) fe_cnt = fe_cnt + 1;
    if (overrun_err) begin
      ov_cnt = ov_cnt + 1;
      ov_cyc = cyc;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop);
    rx_in = 1'b0;
    repeat (BIT) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx_in = d[i];
      repeat (BIT) @(negedge clk);
    end
    rx_in = stop;
    repeat (BIT) @(negedge clk);
  endtask

  initial begin
    rst_n = 1'b0; rx_in = 1'b1; rx_ready = 1'b0;
    repeat (4) @(negedge clk);
    chk("rst_valid", rx_valid, 0);
    chk("rst_data", rx_data, 0);
    chk("rst_busy", busy, 0);
    chk("rst_ferr", frame_err, 0);
    chk("rst_oerr", overrun_err, 0);
    rst_n = 1'b1;
    repeat (20) @(negedge clk);

    // 1: single frame, no consumer
    fe0 = fe_cnt; ov0 = ov_cnt;
    send_frame(8'hA5, 1'b1);
    chk("t1_valid", rx_valid, 1);
    chk("t1_data", rx_data, 8'hA5);
    chk("t1_busy", busy, 0);
    chk("t1_errs", (fe_cnt - fe0) + (ov_cnt - ov0), 0);

    // 2: back-to-back frames with ready held
    rx_ready = 1'b1;
    repeat (2) @(negedge clk);
    chk("t2_a5_taken", rx_valid, 0);
    acc.delete();
    ov0 = ov_cnt;
    send_frame(8'h00, 1'b1);
    send_frame(8'hFF, 1'b1);
    send_frame(8'h3C, 1'b1);
    repeat (10) @(negedge clk);
    chk("t2_count", acc.size(), 3);
    if (acc.size() == 3) begin
      chk("t2_b0", acc[0], 8'h00);
      chk("t2_b1", acc[1], 8'hFF);
      chk("t2_b2", acc[2], 8'h3C);
    end
    chk("t2_oerr", ov_cnt - ov0, 0);
    chk("t2_valid", rx_valid, 0);
    rx_ready = 1'b0;

    // 3: framing error followed by a held-low break
    fe0 = fe_cnt;
    send_frame(8'h55, 1'b0);
    repeat (200) @(negedge clk);
    chk("t3_ferr_once", fe_cnt - fe0, 1);
    chk("t3_valid", rx_valid, 0);
    chk("t3_brk_busy", busy, 1);
    rx_in = 1'b1;
    repeat (8) @(negedge clk);
    chk("t3_idle", busy, 0);
    send_frame(8'h12, 1'b1);
    chk("t3_valid2", rx_valid, 1);
    chk("t3_data2", rx_data, 8'h12);
    rx_ready = 1'b1;
    @(negedge clk);
    rx_ready = 1'b0;
    chk("t3_consumed", rx_valid, 0);
    repeat (20) @(negedge clk);

    // 4: short low glitch on idle line
    fe0 = fe_cnt; ov0 = ov_cnt;
    rx_in = 1'b0;
    repeat (6) @(negedge clk);
    rx_in = 1'b1;
    repeat (4) @(negedge clk);
    chk("t4_busy_mid", busy, 1);
    repeat (30) @(negedge clk);
    chk("t4_busy_end", busy, 0);
    chk("t4_valid", rx_valid, 0);
    chk("t4_errs", (fe_cnt - fe0) + (ov_cnt - ov0), 0);

    // 5: overrun, then a delivery coinciding with an accept
    ov0 = ov_cnt;
    send_frame(8'h11, 1'b1);
    chk("t5_data11", rx_data, 8'h11);
    t1 = cyc;
    send_frame(8'h22, 1'b1);
    chk("t5_ovr_once", ov_cnt - ov0, 1);
    chk("t5_keep_data", rx_data, 8'h11);
    chk("t5_keep_valid", rx_valid, 1);
    off = ov_cyc - t1;
    if (off < 1 || off > 400) off = 1;
    ov0 = ov_cnt; fe0 = fe_cnt;
    acc.delete();
    t2 = cyc;
    fork
      send_frame(8'h22, 1'b1);
      begin
        while (cyc < t2 + off - 1) @(negedge clk);
        rx_ready = 1'b1;
        @(negedge clk);
        rx_ready = 1'b0;
        chk("t5_valid_stays", rx_valid, 1);
      end
    join
    chk("t5_acc_count", acc.size(), 1);
    if (acc.size() == 1) chk("t5_acc_11", acc[0], 8'h11);
    chk("t5_data22", rx_data, 8'h22);
    chk("t5_valid", rx_valid, 1);
    chk("t5_no_ovr", ov_cnt - ov0, 0);
    chk("t5_no_ferr", fe_cnt - fe0, 0);

    // 6: reset mid-frame (during the last data bit)
    fork
      send_frame(8'h81, 1'b1);
      begin
        repeat (BIT * 8 + 8) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        chk("t6_rst_valid", rx_valid, 0);
        chk("t6_rst_data", rx_data, 0);
        chk("t6_rst_busy", busy, 0);
        chk("t6_rst_errs", {frame_err, overrun_err}, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
      end
    join
    fe0 = fe_cnt; ov0 = ov_cnt;
    repeat (20) @(negedge clk);
    chk("t6_no_emit", rx_valid, 0);
    chk("t6_idle", busy, 0);
    send_frame(8'h7E, 1'b1);
    chk("t6_valid", rx_valid, 1);
    chk("t6_data", rx_data, 8'h7E);
    chk("t6_errs", (fe_cnt - fe0) + (ov_cnt - ov0), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
